albacore_mem_arbiter: RTL and testbench

- Shares the single 16-bit albacore memory port (addr/dout/din/we) between two requesters.
- Port 0 is the albacore core; port 1 is the LFSR stream engine or another bus master.
- Round-robin arbitration with an optional bounded lock for atomic read-modify-write sequences.
- Registers the memory command, tracks in-flight reads, and routes read data back to the originating port with a valid strobe.

---
 rtl/albacore_pkg.sv | 25 ++
 rtl/albacore_rd_tracker.sv | 41 ++++
 rtl/albacore_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_albacore_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/albacore_pkg.sv
// Shared definitions for the albacore memory arbiter slice.
//   ALB_DW / ALB_AW : default data / address widths of the memory port
//   PORT_CPU / PORT_AUX : requester ids (core = 0, stream engine / bus master = 1)
//   arb_state_e : arbiter ownership state
//   rd_slot_t   : one stage of the in-flight read tracking pipe
package albacore_pkg;

  localparam int ALB_DW = 16;
  localparam int ALB_AW = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_slot_t;

endpackage

// File: rtl/albacore_rd_tracker.sv
// In-flight read tracker: a MEM_LAT+1 deep shift pipe of {valid, port id}.
// A read pushed at the accepting edge reaches the last stage exactly in the
// cycle where the memory presents its data.
//   clk, rst_n   : clock, async active-low reset (clears all in-flight reads)
//   push_i       : a read command is accepted at this edge
//   push_id_i    : port that issued the read
//   rvalid0_o/1_o: read data for port 0 / port 1 is on mem_din this cycle
module albacore_rd_tracker
  import albacore_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic push_id_i,
  output logic rvalid0_o,
  output logic rvalid1_o
);

  localparam int unsigned DEPTH = unsigned'(MEM_LAT + 1);

  rd_slot_t pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{valid: push_i, id: push_id_i};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rvalid0_o = pipe_q[MEM_LAT].valid && (pipe_q[MEM_LAT].id == PORT_CPU);
  assign rvalid1_o = pipe_q[MEM_LAT].valid && (pipe_q[MEM_LAT].id == PORT_AUX);

endmodule

// File: rtl/albacore_mem_arbiter.sv
// Two-port round-robin arbiter for the single albacore memory port, with a
// bounded ownership lock for read-modify-write sequences.
//   clk, rst_n                 : clock, async active-low reset
//   req/lock/we/addr/wdata 0,1 : per-port command (held until granted)
//   gnt0/gnt1                  : combinational grant; accept = req & gnt
//   rvalid/rdata 0,1           : per-port read return strobe and data
//   mem_addr/mem_dout/mem_we   : registered memory command
//   mem_din                    : memory read data (MEM_LAT after mem_addr)
module albacore_mem_arbiter
  import albacore_pkg::*;
#(
  parameter int DW       = ALB_DW,
  parameter int AW       = ALB_AW,
  parameter int MEM_LAT  = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dout,
  output logic          mem_we,
  input  logic [DW-1:0] mem_din
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  arb_state_e    state_q;
  logic          rr_ptr_q;
  logic [CW-1:0] lock_cnt_q;

  logic          g0, g1;
  logic          acc0, acc1, acc_any, sel_aux, sel_we;
  logic          brk0, brk1;

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_dout_q, mem_dout_d;
  logic          mem_we_q, mem_we_d;

  // A saturated lock yields to a waiting peer; the peer is granted in that
  // same cycle, which leaves rr_ptr on the peer after the accept.
  assign brk0 = (lock_cnt_q == LOCK_MAX) && req1;
  assign brk1 = (lock_cnt_q == LOCK_MAX) && req0;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state_q)
      LOCK0: begin
        if (brk0) g1 = 1'b1;
        else      g0 = req0;
      end
      LOCK1: begin
        if (brk1) g0 = 1'b1;
        else      g1 = req1;
      end
      default: begin
        if (req0 && req1) begin
          // favour the port that was not granted last
          g0 = rr_ptr_q;
          g1 = ~rr_ptr_q;
        end else begin
          g0 = req0;
          g1 = req1;
        end
      end
    endcase
  end

  assign gnt0    = g0 & rst_n;
  assign gnt1    = g1 & rst_n;
  assign acc0    = req0 & gnt0;
  assign acc1    = req1 & gnt1;
  assign acc_any = acc0 | acc1;
  assign sel_aux = acc1;
  assign sel_we  = sel_aux ? we1 : we0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= PORT_CPU;
      lock_cnt_q <= '0;
    end else begin
      if (acc_any) rr_ptr_q <= sel_aux;
      case (state_q)
        ARB: begin
          if (acc0 && lock0) begin
            state_q    <= LOCK0;
            lock_cnt_q <= CW'(1);
          end else if (acc1 && lock1) begin
            state_q    <= LOCK1;
            lock_cnt_q <= CW'(1);
          end
        end
        LOCK0: begin
          if (acc1 || !req0 || (acc0 && !lock0)) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
          end else if (acc0 && (lock_cnt_q != LOCK_MAX)) begin
            lock_cnt_q <= lock_cnt_q + CW'(1);
          end
        end
        LOCK1: begin
          if (acc0 || !req1 || (acc1 && !lock1)) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
          end else if (acc1 && (lock_cnt_q != LOCK_MAX)) begin
            lock_cnt_q <= lock_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q    <= ARB;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    mem_we_d   = acc_any & sel_we;
    if (acc_any) begin
      mem_addr_d = sel_aux ? addr1 : addr0;
      mem_dout_d = sel_aux ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_dout = mem_dout_q;
  assign mem_we   = mem_we_q;

  albacore_rd_tracker #(
    .MEM_LAT (MEM_LAT)
  ) u_rd_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (acc_any & ~sel_we),
    .push_id_i (sel_aux),
    .rvalid0_o (rvalid0),
    .rvalid1_o (rvalid1)
  );

  assign rdata0 = rvalid0 ? mem_din : '0;
  assign rdata1 = rvalid1 ? mem_din : '0;

endmodule

// File: tb/tb_albacore_mem_arbiter.sv
module tb_albacore_mem_arbiter;

  localparam int DW       = 16;
  localparam int AW       = 16;
  localparam int MEM_LAT  = 1;
  localparam int MAX_LOCK = 8;

  typedef struct {
    bit          idle;
    bit          we;
    bit          lock;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct {
    bit          port;
    logic [15:0] data;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_dout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din = '0;

  always #5 clk = ~clk;

  albacore_mem_arbiter #(
    .DW       (DW),
    .AW       (AW),
    .MEM_LAT  (MEM_LAT),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .lock0    (lock0),
    .lock1    (lock1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_we   (mem_we),
    .mem_din  (mem_din)
  );

  // Memory model: unwritten locations hold a fixed pattern, 0x0010 holds 0xBEEF.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A00);
  endfunction

  logic [15:0]  mem [256];
  logic [255:0] wr_map = '0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:0]]    <= mem_dout;
      wr_map[mem_addr[7:0]] <= 1'b1;
    end
    mem_din <= wr_map[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr);
  end

  cmd_t    q0[$], q1[$];
  cmd_t    cur0, cur1;
  bit      exp_acc[$];
  rd_exp_t exp_rd[$];
  int      due_q[$];
  int      checks   = 0;
  int      errors   = 0;
  int      timeouts = 0;
  int      cyc      = 0;
  bit      fin_req  = 0;
  bit      pend     = 0;
  cmd_t    pend_cmd;

  function automatic cmd_t mk(bit idle, bit we, bit lock, logic [15:0] a, logic [15:0] d);
    cmd_t c;
    c.idle = idle; c.we = we; c.lock = lock; c.addr = a; c.wdata = d;
    return c;
  endfunction

  function automatic rd_exp_t mkr(bit p, logic [15:0] d);
    rd_exp_t r;
    r.port = p; r.data = d;
    return r;
  endfunction

  // Scoreboard monitor: samples on the falling edge.
  always @(negedge clk) begin : monitor
    bit      a0, a1, ep;
    int      due;
    rd_exp_t e;
    cyc++;
    if (!rst_n) begin
      checks++;
      if (gnt0 || gnt1 || rvalid0 || rvalid1 || mem_we || mem_addr != '0 ||
          mem_dout != '0 || rdata0 != '0 || rdata1 != '0) begin
        errors++;
        $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b we=%b addr=%h dout=%h rd0=%h rd1=%h, want all 0",
                 gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_addr, mem_dout, rdata0, rdata1);
      end
      due_q.delete();
      pend = 0;
    end else begin
      checks++;
      if (pend) begin
        if (mem_addr !== pend_cmd.addr || mem_we !== pend_cmd.we ||
            (pend_cmd.we && mem_dout !== pend_cmd.wdata)) begin
          errors++;
          $display("FAIL mem_cmd: got addr=%h we=%b dout=%h, want addr=%h we=%b dout=%h",
                   mem_addr, mem_we, mem_dout, pend_cmd.addr, pend_cmd.we, pend_cmd.wdata);
        end
      end else if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL mem_we_idle: got mem_we=%b, want 0", mem_we);
      end
      pend = 0;

      if (rvalid0 || rvalid1) begin
        checks++;
        if (exp_rd.size() == 0 || due_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid: got rvalid=%b%b at cycle %0d, want none", rvalid0, rvalid1, cyc);
        end else begin
          e   = exp_rd.pop_front();
          due = due_q.pop_front();
          if ((rvalid0 && rvalid1) || rvalid1 != e.port ||
              (rvalid1 ? rdata1 : rdata0) !== e.data || due != cyc) begin
            errors++;
            $display("FAIL read_return: got rvalid=%b%b data=%h cycle=%0d, want port=%0d data=%h cycle=%0d",
                     rvalid0, rvalid1, rvalid1 ? rdata1 : rdata0, cyc, e.port, e.data, due);
          end
        end
      end

      a0 = req0 && gnt0;
      a1 = req1 && gnt1;
      if (a0 || a1) begin
        checks++;
        if (exp_acc.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: got gnt=%b%b, want none", gnt0, gnt1);
        end else begin
          ep = exp_acc.pop_front();
          if ((a0 && a1) || a1 != ep) begin
            errors++;
            $display("FAIL grant_order: got gnt=%b%b, want port %0d", gnt0, gnt1, ep);
          end
          pend     = 1;
          pend_cmd = ep ? cur1 : cur0;
          if (!pend_cmd.we) due_q.push_back(cyc + 1 + MEM_LAT);
        end
      end
    end

    if (fin_req) begin
      fin_req = 0;
      checks++;
      if (exp_acc.size() != 0) begin
        errors++;
        $display("FAIL grants_missing: got %0d outstanding, want 0", exp_acc.size());
      end
      checks++;
      if (exp_rd.size() != 0) begin
        errors++;
        $display("FAIL reads_missing: got %0d outstanding, want 0", exp_rd.size());
      end
      checks++;
      if (timeouts != 0) begin
        errors++;
        $display("FAIL drive_timeout: got %0d timeouts, want 0", timeouts);
      end
    end
  end

  task automatic apply();
    if (q0.size() != 0) begin
      cur0 = q0[0];
      req0 = !cur0.idle; we0 = cur0.we; lock0 = cur0.lock && !cur0.idle;
      addr0 = cur0.addr; wdata0 = cur0.wdata;
    end else begin
      req0 = 0; lock0 = 0; we0 = 0;
    end
    if (q1.size() != 0) begin
      cur1 = q1[0];
      req1 = !cur1.idle; we1 = cur1.we; lock1 = cur1.lock && !cur1.idle;
      addr1 = cur1.addr; wdata1 = cur1.wdata;
    end else begin
      req1 = 0; lock1 = 0; we1 = 0;
    end
  endtask

  // Presents each port's queued commands, holding each until accepted;
  // idle entries drop req for exactly one cycle.
  task automatic run(input int budget, input int drain);
    int n = 0;
    bit s0, s1;
    apply();
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(negedge clk);
      s0 = req0 && gnt0;
      s1 = req1 && gnt1;
      @(posedge clk);
      #1;
      if (q0.size() != 0 && (s0 || q0[0].idle)) q0.delete(0);
      if (q1.size() != 0 && (s1 || q1[0].idle)) q1.delete(0);
      apply();
      n++;
    end
    if (n >= budget) begin
      timeouts++;
      q0.delete();
      q1.delete();
      apply();
    end
    if (drain > 0) begin
      repeat (drain) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 0; req0 = 1; req1 = 1; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    req0 = 0; req1 = 0; rst_n = 1;
    @(posedge clk);
    #1;

    // Single read by port 0 of 0x0010
    q0.push_back(mk(0, 0, 0, 16'h0010, 16'h0000));
    exp_acc.push_back(0);
    exp_rd.push_back(mkr(0, 16'hBEEF));
    run(20, 4);

    // Both ports streaming reads: last grant was port 0, so port 1 leads
    q0.push_back(mk(0, 0, 0, 16'h0030, 0));
    q0.push_back(mk(0, 0, 0, 16'h0031, 0));
    q0.push_back(mk(0, 0, 0, 16'h0032, 0));
    q1.push_back(mk(0, 0, 0, 16'h0040, 0));
    q1.push_back(mk(0, 0, 0, 16'h0041, 0));
    q1.push_back(mk(0, 0, 0, 16'h0042, 0));
    for (int i = 0; i < 3; i++) begin
      exp_acc.push_back(1);
      exp_acc.push_back(0);
    end
    exp_rd.push_back(mkr(1, 16'h5A40));
    exp_rd.push_back(mkr(0, 16'h5A30));
    exp_rd.push_back(mkr(1, 16'h5A41));
    exp_rd.push_back(mkr(0, 16'h5A31));
    exp_rd.push_back(mkr(1, 16'h5A42));
    exp_rd.push_back(mkr(0, 16'h5A32));
    run(40, 4);

    // Port 1 writes 0x1234 to 0x0020, port 0 reads it back next cycle
    q1.push_back(mk(0, 1, 0, 16'h0020, 16'h1234));
    q0.push_back(mk(1, 0, 0, 16'h0000, 0));
    q0.push_back(mk(0, 0, 0, 16'h0020, 0));
    exp_acc.push_back(1);
    exp_acc.push_back(0);
    exp_rd.push_back(mkr(0, 16'h1234));
    run(20, 4);

    // Port 0 locked for 10 reads while port 1 waits: 8 grants, break, resume
    for (int i = 0; i < 10; i++) begin
      q0.push_back(mk(0, 0, (i != 9), 16'h0050 + 16'(i), 0));
    end
    q1.push_back(mk(1, 0, 0, 16'h0000, 0));
    q1.push_back(mk(0, 0, 0, 16'h0060, 0));
    for (int i = 0; i < 8; i++) exp_acc.push_back(0);
    exp_acc.push_back(1);
    exp_acc.push_back(0);
    exp_acc.push_back(0);
    for (int i = 0; i < 8; i++) exp_rd.push_back(mkr(0, 16'h5A50 + 16'(i)));
    exp_rd.push_back(mkr(1, 16'h5A60));
    exp_rd.push_back(mkr(0, 16'h5A58));
    exp_rd.push_back(mkr(0, 16'h5A59));
    run(60, 4);

    // Lock taken, then abandoned by dropping req0 for one cycle
    q0.push_back(mk(0, 0, 1, 16'h0070, 0));
    q0.push_back(mk(1, 0, 0, 16'h0000, 0));
    q0.push_back(mk(0, 0, 0, 16'h0071, 0));
    q1.push_back(mk(1, 0, 0, 16'h0000, 0));
    q1.push_back(mk(0, 0, 0, 16'h0080, 0));
    exp_acc.push_back(0);
    exp_acc.push_back(1);
    exp_acc.push_back(0);
    exp_rd.push_back(mkr(0, 16'h5A70));
    exp_rd.push_back(mkr(1, 16'h5A80));
    exp_rd.push_back(mkr(0, 16'h5A71));
    run(30, 4);

    // Reset during an in-flight read: that read never returns
    q0.push_back(mk(0, 0, 0, 16'h0010, 0));
    exp_acc.push_back(0);
    run(20, 0);
    rst_n = 0; req0 = 1; req1 = 1; lock0 = 0; lock1 = 0;
    repeat (2) @(posedge clk);
    #1;
    // both request on the first cycle after reset: port 1 wins
    q0.push_back(mk(0, 0, 0, 16'h0090, 0));
    q1.push_back(mk(0, 0, 0, 16'h00A0, 0));
    exp_acc.push_back(1);
    exp_acc.push_back(0);
    exp_rd.push_back(mkr(1, 16'h5AA0));
    exp_rd.push_back(mkr(0, 16'h5A90));
    apply();
    rst_n = 1;
    run(30, 5);

    fin_req = 1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
